ula_contention: RTL and testbench

//  CPU clock sequencer for the ULA: divides clk_ula (14 MHz) by 4 into the 3.5 MHz Z80 clock.

---
 rtl/ula_contention.sv | 89 ++++++++
 tb/tb_ula_contention.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ula_contention.sv
// ULA CPU clock sequencer: divides clk_ula by 4 into the Z80 clock and stretches the
// high phase while the CPU touches contended memory or even-port I/O in a display slot.
module ula_contention #(
    parameter logic [8:0] CONT_START = 9'd0,
    parameter logic [8:0] CONT_LINES = 9'd192
) (
    input  logic        clk_ula,
    input  logic        nreset,
    input  logic [8:0]  hc,
    input  logic [8:0]  vc,
    input  logic        cont_en,
    input  logic [15:0] a,
    input  logic        mreq_n,
    input  logic        iorq_n,
    output logic        clk_cpu,
    output logic        cpu_rise,
    output logic        cpu_fall,
    output logic        contended,
    output logic [15:0] stall_cnt
);

    logic [1:0]  cnt_q, cnt_d;
    logic        clk_cpu_q, clk_cpu_d;
    logic        cpu_rise_q, cpu_rise_d;
    logic        cpu_fall_q, cpu_fall_d;
    logic        contended_q, contended_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic [8:0]  hc_off;
    logic [9:0]  hc_end;
    logic        win;
    logic        req;
    logic        stall;
    logic        hold;
    logic        frame_start;
    logic        unused_bits;

    // Slot index is hc_off[3:1]; slots 6 and 7 of every 8 are left free for the CPU.
    assign hc_off = hc - CONT_START;
    assign hc_end = {1'b0, CONT_START} + 10'd256;
    assign win    = (vc < CONT_LINES) && (hc >= CONT_START) &&
                    ({1'b0, hc} < hc_end) && (hc_off[3:1] < 3'd6);

    assign req         = (!mreq_n && (a[15:14] == 2'b01)) || (!iorq_n && !a[0]);
    assign stall       = cont_en && win && req;
    assign hold        = (cnt_q == 2'd3) && stall;
    assign frame_start = (hc == 9'd0) && (vc == 9'd0);
    assign unused_bits = ^{a[13:1], hc_off[8:4], hc_off[0]};

    always_comb begin
        cnt_d       = hold ? cnt_q : cnt_q + 2'd1;
        clk_cpu_d   = cnt_d[1];
        cpu_rise_d  = (cnt_d == 2'd2) && (cnt_q != 2'd2);
        cpu_fall_d  = (cnt_d == 2'd0) && (cnt_q == 2'd3);
        contended_d = hold;
        stall_cnt_d = stall_cnt_q;
        // Frame clear takes priority over a coincident increment.
        if (frame_start) begin
            stall_cnt_d = 16'd0;
        end else if (hold && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_ula or negedge nreset) begin
        if (!nreset) begin
            cnt_q       <= 2'd0;
            clk_cpu_q   <= 1'b0;
            cpu_rise_q  <= 1'b0;
            cpu_fall_q  <= 1'b0;
            contended_q <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            cnt_q       <= cnt_d;
            clk_cpu_q   <= clk_cpu_d;
            cpu_rise_q  <= cpu_rise_d;
            cpu_fall_q  <= cpu_fall_d;
            contended_q <= contended_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign clk_cpu   = clk_cpu_q;
    assign cpu_rise  = cpu_rise_q;
    assign cpu_fall  = cpu_fall_q;
    assign contended = contended_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_ula_contention.sv
// Directed self-checking bench for ula_contention: free run, window/request decoding,
// async reset mid-stall, stall counter saturation and frame clear.
module tb_ula_contention;

    logic        clk_ula;
    logic        nreset;
    logic [8:0]  hc;
    logic [8:0]  vc;
    logic        cont_en;
    logic [15:0] a;
    logic        mreq_n;
    logic        iorq_n;
    logic        clk_cpu;
    logic        cpu_rise;
    logic        cpu_fall;
    logic        contended;
    logic [15:0] stall_cnt;

    int checks;
    int failures;

    ula_contention dut (
        .clk_ula   (clk_ula),
        .nreset    (nreset),
        .hc        (hc),
        .vc        (vc),
        .cont_en   (cont_en),
        .a         (a),
        .mreq_n    (mreq_n),
        .iorq_n    (iorq_n),
        .clk_cpu   (clk_cpu),
        .cpu_rise  (cpu_rise),
        .cpu_fall  (cpu_fall),
        .contended (contended),
        .stall_cnt (stall_cnt)
    );

    initial clk_ula = 1'b0;
    always #5 clk_ula = ~clk_ula;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clk_ula edge; returns at the following falling edge, where inputs change and outputs are sampled.
    task automatic tick();
        @(posedge clk_ula);
        @(negedge clk_ula);
    endtask

    task automatic applyReset();
        nreset  = 1'b0;
        cont_en = 1'b0;
        mreq_n  = 1'b1;
        iorq_n  = 1'b1;
        a       = 16'h0000;
        hc      = 9'd100;
        vc      = 9'd300;
        @(negedge clk_ula);
        @(negedge clk_ula);
        nreset = 1'b1;
    endtask

    // Bring the phase counter to 3 outside the window, then present one access at (line, col).
    task automatic applyStimulus(input string tag, input logic [15:0] addr, input logic mreq,
                                 input logic iorq, input logic en, input logic [8:0] line,
                                 input logic [8:0] col, input logic exp_stall);
        applyReset();
        a       = addr;
        mreq_n  = mreq;
        iorq_n  = iorq;
        cont_en = en;
        vc      = line;
        hc      = 9'd300;
        repeat (3) tick();
        hc = col;
        tick();
        checkOutput({tag, "_contended"}, 32'(contended), 32'(exp_stall));
        checkOutput({tag, "_clk_cpu"},   32'(clk_cpu),   32'(exp_stall));
        checkOutput({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(exp_stall));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nreset   = 1'b0;
        cont_en  = 1'b0;
        mreq_n   = 1'b1;
        iorq_n   = 1'b1;
        a        = 16'h0000;
        hc       = 9'd100;
        vc       = 9'd300;

        @(negedge clk_ula);
        checkOutput("rst_clk_cpu",   32'(clk_cpu),   32'd0);
        checkOutput("rst_cpu_rise",  32'(cpu_rise),  32'd0);
        checkOutput("rst_cpu_fall",  32'(cpu_fall),  32'd0);
        checkOutput("rst_contended", 32'(contended), 32'd0);
        checkOutput("rst_stall_cnt", 32'(stall_cnt), 32'd0);

        // Free run: after release clk_cpu follows 0,1,1,0 repeating.
        applyReset();
        for (int k = 1; k <= 8; k++) begin
            tick();
            checkOutput($sformatf("free_clk_%0d", k),  32'(clk_cpu),   32'((k % 4) >= 2));
            checkOutput($sformatf("free_rise_%0d", k), 32'(cpu_rise),  32'((k % 4) == 2));
            checkOutput($sformatf("free_fall_%0d", k), 32'(cpu_fall),  32'((k % 4) == 0));
            checkOutput($sformatf("free_cont_%0d", k), 32'(contended), 32'd0);
        end

        // Contended memory held across slots 0..5 (hc 0..11, two clk_ula per pixel).
        applyReset();
        a = 16'h4000; mreq_n = 1'b0; cont_en = 1'b1; vc = 9'd10; hc = 9'd300;
        repeat (3) tick();
        for (int i = 0; i < 24; i++) begin
            hc = 9'(i / 2);
            tick();
            checkOutput($sformatf("mem_hold_clk_%0d", i),  32'(clk_cpu),   32'd1);
            checkOutput($sformatf("mem_hold_cont_%0d", i), 32'(contended), 32'd1);
        end
        hc = 9'd12;
        tick();
        checkOutput("mem_release_clk",  32'(clk_cpu),   32'd0);
        checkOutput("mem_release_fall", 32'(cpu_fall),  32'd1);
        checkOutput("mem_release_cont", 32'(contended), 32'd0);
        checkOutput("mem_stall_cnt",    32'(stall_cnt), 32'd24);

        // Request and window decoding.
        applyStimulus("mem4000",      16'h4000, 1'b0, 1'b1, 1'b1, 9'd10,  9'd0,   1'b1);
        applyStimulus("mem8000",      16'h8000, 1'b0, 1'b1, 1'b1, 9'd10,  9'd0,   1'b0);
        applyStimulus("memC000",      16'hC000, 1'b0, 1'b1, 1'b1, 9'd10,  9'd0,   1'b0);
        applyStimulus("no_mreq",      16'h4000, 1'b1, 1'b1, 1'b1, 9'd10,  9'd0,   1'b0);
        applyStimulus("mem_disabled", 16'h4000, 1'b0, 1'b1, 1'b0, 9'd10,  9'd0,   1'b0);
        applyStimulus("io_odd",       16'h00FF, 1'b1, 1'b0, 1'b1, 9'd10,  9'd0,   1'b0);
        applyStimulus("io_even",      16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd0,   1'b1);
        applyStimulus("io_vc200",     16'h00FE, 1'b1, 1'b0, 1'b1, 9'd200, 9'd0,   1'b0);
        applyStimulus("io_vc191",     16'h00FE, 1'b1, 1'b0, 1'b1, 9'd191, 9'd0,   1'b1);
        applyStimulus("io_vc192",     16'h00FE, 1'b1, 1'b0, 1'b1, 9'd192, 9'd0,   1'b0);
        applyStimulus("io_hc11",      16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd11,  1'b1);
        applyStimulus("io_hc12",      16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd12,  1'b0);
        applyStimulus("io_hc15",      16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd15,  1'b0);
        applyStimulus("io_hc16",      16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd16,  1'b1);
        applyStimulus("io_hc250",     16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd250, 1'b1);
        applyStimulus("io_hc255",     16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd255, 1'b0);
        applyStimulus("io_hc256",     16'h00FE, 1'b1, 1'b0, 1'b1, 9'd10,  9'd256, 1'b0);

        // Asynchronous reset in the middle of a stall.
        applyReset();
        a = 16'h4000; mreq_n = 1'b0; cont_en = 1'b1; vc = 9'd10; hc = 9'd300;
        repeat (3) tick();
        hc = 9'd0;
        repeat (5) tick();
        checkOutput("midstall_cont",   32'(contended), 32'd1);
        checkOutput("midstall_cnt",    32'(stall_cnt), 32'd5);
        #1 nreset = 1'b0;
        #1;
        checkOutput("async_rst_clk",   32'(clk_cpu),   32'd0);
        checkOutput("async_rst_cont",  32'(contended), 32'd0);
        checkOutput("async_rst_cnt",   32'(stall_cnt), 32'd0);
        @(negedge clk_ula);
        cont_en = 1'b0;
        nreset  = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checkOutput($sformatf("post_rst_clk_%0d", k), 32'(clk_cpu), 32'((k % 4) >= 2));
        end

        // Saturation, then frame clear coinciding with a stall, then clear without one.
        applyReset();
        a = 16'h4000; mreq_n = 1'b0; cont_en = 1'b1; vc = 9'd10; hc = 9'd300;
        repeat (3) tick();
        hc = 9'd0;
        repeat (65534) tick();
        checkOutput("sat_fffe", 32'(stall_cnt), 32'h0000FFFE);
        tick();
        checkOutput("sat_ffff", 32'(stall_cnt), 32'h0000FFFF);
        repeat (3) tick();
        checkOutput("sat_hold",      32'(stall_cnt), 32'h0000FFFF);
        checkOutput("sat_hold_cont", 32'(contended), 32'd1);
        vc = 9'd0;
        tick();
        checkOutput("clear_with_stall",      32'(stall_cnt), 32'd0);
        checkOutput("clear_with_stall_cont", 32'(contended), 32'd1);
        hc = 9'd1;
        tick();
        checkOutput("after_clear_inc", 32'(stall_cnt), 32'd1);
        cont_en = 1'b0; hc = 9'd5;
        tick();
        checkOutput("disable_cont", 32'(contended), 32'd0);
        checkOutput("disable_fall", 32'(cpu_fall),  32'd1);
        repeat (4) tick();
        checkOutput("disable_holds_cnt", 32'(stall_cnt), 32'd1);
        hc = 9'd0;
        tick();
        checkOutput("frame_clear", 32'(stall_cnt), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
